// File: rtl/openhmc_sync_fifo_chain.sv
// openhmc_sync_fifo_chain: fall-through register-chain FIFO, head at stage 0, with registered status flags
module openhmc_sync_fifo_chain #(
  parameter int DWIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AFULL_LVL = 6,
  parameter int AEMPTY_LVL = 1,
  localparam int LVLW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              shift_in,
  input  logic [DWIDTH-1:0] d_in,
  input  logic              shift_out,
  output logic [DWIDTH-1:0] d_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [LVLW-1:0]   fill_level,
  output logic              overflow,
  output logic              underflow
);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] nxt [DEPTH];
  logic push_ok, pop_ok;
  logic [LVLW-1:0] cnt_nx;
  assign push_ok = shift_in && (!full || shift_out);
  assign pop_ok = shift_out && !empty;
  assign cnt_nx = (push_ok && !pop_ok) ? fill_level + LVLW'(1) :
                  (pop_ok && !push_ok) ? fill_level - LVLW'(1) : fill_level;
  assign d_out = mem[0];
  // stages beyond the valid region hold their data so d_out keeps the last word after a drain
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      nxt[k] = mem[k];
      if (pop_ok)
        nxt[k] = (push_ok && fill_level == LVLW'(k + 1)) ? d_in :
                 (LVLW'(k + 1) < fill_level) ? mem[k < DEPTH - 1 ? k + 1 : k] : mem[k];
      else if (push_ok && fill_level == LVLW'(k))
        nxt[k] = d_in;
    end
  end
  always_ff @(posedge clk) begin
    if (!res_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      fill_level <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= nxt[k];
      fill_level <= cnt_nx;
      empty <= cnt_nx == '0;
      full <= cnt_nx == LVLW'(DEPTH);
      almost_full <= cnt_nx >= LVLW'(AFULL_LVL);
      almost_empty <= cnt_nx <= LVLW'(AEMPTY_LVL);
      overflow <= overflow | (shift_in && full && !shift_out);
      underflow <= underflow | (shift_out && empty);
    end
  end
endmodule

// File: tb/tb_openhmc_sync_fifo_chain.sv
// tb_openhmc_sync_fifo_chain: directed scenario tasks for the register-chain FIFO
module tb_openhmc_sync_fifo_chain;
  logic clk = 0, res_n = 0, shift_in = 0, shift_out = 0;
  logic [7:0] d_in = 0, d_out;
  logic empty, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0] fill_level;
  int pass = 0, total = 0;

  openhmc_sync_fifo_chain dut (
    .clk(clk), .res_n(res_n), .shift_in(shift_in), .d_in(d_in), .shift_out(shift_out),
    .d_out(d_out), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .fill_level(fill_level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_n = 0; shift_in = 0; shift_out = 0;
    step();
    res_n = 1;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      shift_in = 1; d_in = base + 8'(i);
      step();
    end
    shift_in = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else pass++;
    total++; if (fill_level !== 4'd0) $display("FAIL reset_fill got %0d want 0", fill_level); else pass++;
    total++; if ({full, almost_full, almost_empty, overflow, underflow} !== 5'b00100)
      $display("FAIL reset_flags got %b want 00100", {full, almost_full, almost_empty, overflow, underflow}); else pass++;
    total++; if (d_out !== 8'h00) $display("FAIL reset_dout got %h want 00", d_out); else pass++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      shift_in = 1; d_in = 8'(i);
      step();
      total++; if (fill_level !== 4'(i)) $display("FAIL fill_level[%0d] got %0d want %0d", i, fill_level, i); else pass++;
      total++; if ({full, almost_full, almost_empty, empty} !== {i == 8, i >= 6, i <= 1, 1'b0})
        $display("FAIL fill_flags[%0d] got %b want %b", i, {full, almost_full, almost_empty, empty}, {i == 8, i >= 6, i <= 1, 1'b0}); else pass++;
      total++; if (d_out !== 8'h01) $display("FAIL fill_dout[%0d] got %h want 01", i, d_out); else pass++;
    end
    shift_in = 0;
  endtask

  task automatic test_overflow();
    shift_in = 1; d_in = 8'h09;
    step();
    shift_in = 0;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else pass++;
    total++; if (fill_level !== 4'd8 || full !== 1'b1) $display("FAIL ovf_fill got %0d/%b want 8/1", fill_level, full); else pass++;
    for (int i = 1; i <= 8; i++) begin
      total++; if (d_out !== 8'(i)) $display("FAIL ovf_drain[%0d] got %h want %h", i, d_out, 8'(i)); else pass++;
      shift_out = 1;
      step();
    end
    shift_out = 0;
    total++; if (empty !== 1'b1) $display("FAIL ovf_drained_empty got %b want 1", empty); else pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(8, 8'h01);
    for (int j = 1; j <= 4; j++) begin
      shift_in = 1; d_in = 8'hAA; shift_out = 1;
      step();
      total++; if (d_out !== 8'(j + 1)) $display("FAIL b2b_dout[%0d] got %h want %h", j, d_out, 8'(j + 1)); else pass++;
      total++; if ({full, overflow, fill_level} !== {1'b1, 1'b0, 4'd8})
        $display("FAIL b2b_flags[%0d] got %b%b/%0d want 10/8", j, full, overflow, fill_level); else pass++;
    end
    shift_in = 0; shift_out = 0;
  endtask

  task automatic test_underflow();
    logic [7:0] exp [8];
    exp = '{8'h05, 8'h06, 8'h07, 8'h08, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    for (int i = 0; i < 8; i++) begin
      total++; if (d_out !== exp[i]) $display("FAIL drain[%0d] got %h want %h", i, d_out, exp[i]); else pass++;
      shift_out = 1;
      step();
    end
    total++; if (underflow !== 1'b0) $display("FAIL early_underflow got %b want 0", underflow); else pass++;
    step();
    shift_out = 0;
    total++; if ({empty, underflow, fill_level} !== {1'b1, 1'b1, 4'd0})
      $display("FAIL udf_state got %b%b/%0d want 11/0", empty, underflow, fill_level); else pass++;
    total++; if (d_out !== 8'hAA) $display("FAIL udf_dout_hold got %h want aa", d_out); else pass++;
  endtask

  task automatic test_push_pop_empty();
    shift_in = 1; d_in = 8'h5C; shift_out = 1;
    step();
    shift_in = 0; shift_out = 0;
    total++; if (fill_level !== 4'd1 || empty !== 1'b0) $display("FAIL pp_empty_fill got %0d/%b want 1/0", fill_level, empty); else pass++;
    total++; if (d_out !== 8'h5C) $display("FAIL pp_empty_dout got %h want 5c", d_out); else pass++;
    total++; if (underflow !== 1'b1) $display("FAIL pp_empty_udf got %b want 1", underflow); else pass++;
  endtask

  task automatic test_mid_reset();
    fill(4, 8'h40);
    total++; if (fill_level !== 4'd5) $display("FAIL pre_reset_fill got %0d want 5", fill_level); else pass++;
    res_n = 0; shift_in = 1; d_in = 8'h77;
    step();
    res_n = 1; shift_in = 0;
    total++; if ({empty, fill_level, d_out} !== {1'b1, 4'd0, 8'h00})
      $display("FAIL mid_reset got %b/%0d/%h want 1/0/00", empty, fill_level, d_out); else pass++;
    total++; if ({full, almost_full, almost_empty, overflow, underflow} !== 5'b00100)
      $display("FAIL mid_reset_flags got %b want 00100", {full, almost_full, almost_empty, overflow, underflow}); else pass++;
    shift_in = 1; d_in = 8'h33;
    step();
    shift_in = 0;
    total++; if (d_out !== 8'h33 || empty !== 1'b0) $display("FAIL post_reset_push got %h/%b want 33/0", d_out, empty); else pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_push_pop_empty();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
